// File: rtl/id_operand_scoreboard_pkg.sv
// Shared constants and types for the decode-stage operand/hazard block.
// Register numbers, control encodings and operand-source selector.
package id_operand_scoreboard_pkg;

    localparam int NUM_RD_DEF  = 2;
    localparam int NUM_FWD_DEF = 2;

    localparam logic [4:0] HiReg = 5'd30;
    localparam logic [4:0] LoReg = 5'd31;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;

    typedef enum logic [1:0] {
        SRC_IMM = 2'd0,
        SRC_RF  = 2'd1,
        SRC_FWD = 2'd2
    } opnd_src_e;

endpackage

// File: rtl/id_operand_scoreboard_fwd_mux.sv
// Single-port operand select: youngest matching forward source,
// else regfile data, else immediate; also reports late data.
module id_fwd_mux
    import id_operand_scoreboard_pkg::*;
#(
    parameter int REG_W   = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = NUM_FWD_DEF
) (
    input  logic                      rd_en_i,
    input  logic [ADDR_W-1:0]         rd_addr_i,
    input  logic [REG_W-1:0]          rf_data_i,
    input  logic [REG_W-1:0]          imm_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr_i,
    input  logic [NUM_FWD*REG_W-1:0]  fwd_data_i,
    input  logic [NUM_FWD-1:0]        fwd_late_i,
    output logic [REG_W-1:0]          data_o,
    output logic                      late_o
);

    logic             hit;
    logic [REG_W-1:0] fdata;
    logic             flate;
    opnd_src_e        src;

    // Scan oldest to youngest so the youngest match overrides.
    always_comb begin
        hit   = 1'b0;
        fdata = '0;
        flate = 1'b0;
        for (int j = NUM_FWD - 1; j >= 0; j--) begin
            if (fwd_we_i[j] == WriteEnable &&
                fwd_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i) begin
                hit   = 1'b1;
                fdata = fwd_data_i[j*REG_W +: REG_W];
                flate = fwd_late_i[j];
            end
        end
    end

    // Pick the operand source and drive data and late flag.
    always_comb begin
        src    = SRC_IMM;
        data_o = imm_i;
        late_o = 1'b0;
        unique case (1'b1)
            !rd_en_i: src = SRC_IMM;
            hit:      src = SRC_FWD;
            default:  src = SRC_RF;
        endcase
        unique case (src)
            SRC_FWD: begin
                data_o = fdata;
                late_o = flate;
            end
            SRC_RF:  data_o = rf_data_i;
            default: data_o = imm_i;
        endcase
    end

endmodule

// File: rtl/id_operand_scoreboard.sv
// Decode-stage operand fetch with busy scoreboard for long-latency
// producers, RAW/WAW stall request and a sticky stall watchdog.
module id_operand_scoreboard
    import id_operand_scoreboard_pkg::*;
#(
    parameter int REG_W    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int NUM_FWD  = NUM_FWD_DEF,
    parameter int WDOG_MAX = 63
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RD-1:0]         rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr_i,
    input  logic [NUM_RD*REG_W-1:0]   rf_data_i,
    input  logic [REG_W-1:0]          imm_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr_i,
    input  logic [NUM_FWD*REG_W-1:0]  fwd_data_i,
    input  logic [NUM_FWD-1:0]        fwd_late_i,
    input  logic                      issue_i,
    input  logic [ADDR_W-1:0]         issue_wd_i,
    input  logic                      issue_long_i,
    input  logic                      wb_valid_i,
    input  logic [ADDR_W-1:0]         wb_addr_i,
    input  logic                      flush_i,
    output logic [NUM_RD*REG_W-1:0]   operand_o,
    output logic                      stallreq_o,
    output logic [2**ADDR_W-1:0]      busy_o,
    output logic [ADDR_W:0]           pend_cnt_o,
    output logic                      wdog_o
);

    localparam int NREG = 2**ADDR_W;
    localparam int CW   = $clog2(WDOG_MAX + 1);

    localparam logic [CW-1:0]   WMAX    = CW'(WDOG_MAX);
    localparam logic [CW-1:0]   WONE    = CW'(1);
    localparam logic [ADDR_W:0] PC_ONE  = (ADDR_W+1)'(1);

    logic [NUM_RD*REG_W-1:0] mux_data;
    logic [NUM_RD-1:0]       mux_late;

    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]   pend_q, pend_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic              wdog_q, wdog_d;

    logic raw;
    logic waw;
    logic stall;
    logic set_en;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        id_fwd_mux #(
            .REG_W   (REG_W),
            .ADDR_W  (ADDR_W),
            .NUM_FWD (NUM_FWD)
        ) u_mux (
            .rd_en_i    (rd_en_i[k]),
            .rd_addr_i  (rd_addr_i[k*ADDR_W +: ADDR_W]),
            .rf_data_i  (rf_data_i[k*REG_W +: REG_W]),
            .imm_i      (imm_i),
            .fwd_we_i   (fwd_we_i),
            .fwd_addr_i (fwd_addr_i),
            .fwd_data_i (fwd_data_i),
            .fwd_late_i (fwd_late_i),
            .data_o     (mux_data[k*REG_W +: REG_W]),
            .late_o     (mux_late[k])
        );
    end

    // Any read of a busy register or of late forwarded data is a RAW hazard.
    always_comb begin
        raw = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (rd_en_i[k] &&
                (busy_q[rd_addr_i[k*ADDR_W +: ADDR_W]] || mux_late[k])) begin
                raw = 1'b1;
            end
        end
    end

    assign waw    = issue_i && issue_long_i && busy_q[issue_wd_i];
    assign stall  = (raw || waw) && !flush_i && !rst;
    assign set_en = issue_i && issue_long_i && !stall && !flush_i;

    // Scoreboard update: clear on writeback, then set so set wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i) begin
            busy_d[wb_addr_i] = 1'b0;
        end
        if (set_en) begin
            busy_d[issue_wd_i] = WriteEnable;
        end
        pend_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (busy_d[i]) begin
                pend_d = pend_d + PC_ONE;
            end
        end
    end

    // Watchdog counts consecutive stall cycles and saturates.
    always_comb begin
        wcnt_d = '0;
        if (stall) begin
            wcnt_d = (wcnt_q == WMAX) ? wcnt_q : wcnt_q + WONE;
        end
        wdog_d = wdog_q || (wcnt_d == WMAX);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            pend_q <= '0;
            wcnt_q <= '0;
            wdog_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            wcnt_q <= wcnt_d;
            wdog_q <= wdog_d;
        end
    end

    assign operand_o  = rst ? '0 : mux_data;
    assign stallreq_o = stall ? Stop : NoStop;
    assign busy_o     = busy_q;
    assign pend_cnt_o = pend_q;
    assign wdog_o     = wdog_q;

endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Directed bench for id_operand_scoreboard: forwarding priority,
// load-use, long ops, set/clear overlap, flush and watchdog.
module tb_id_operand_scoreboard;

    localparam int REG_W  = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;
    localparam int NFWD   = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NRD-1:0]         rd_en;
    logic [NRD*ADDR_W-1:0]  rd_addr;
    logic [NRD*REG_W-1:0]   rf_data;
    logic [REG_W-1:0]       imm;
    logic [NFWD-1:0]        fwd_we;
    logic [NFWD*ADDR_W-1:0] fwd_addr;
    logic [NFWD*REG_W-1:0]  fwd_data;
    logic [NFWD-1:0]        fwd_late;
    logic                   issue;
    logic [ADDR_W-1:0]      issue_wd;
    logic                   issue_long;
    logic                   wb_valid;
    logic [ADDR_W-1:0]      wb_addr;
    logic                   flush;
    logic [NRD*REG_W-1:0]   operand;
    logic                   stallreq;
    logic [31:0]            busy;
    logic [ADDR_W:0]        pend_cnt;
    logic                   wdog;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_operand_scoreboard #(
        .REG_W    (REG_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NRD),
        .NUM_FWD  (NFWD),
        .WDOG_MAX (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en_i      (rd_en),
        .rd_addr_i    (rd_addr),
        .rf_data_i    (rf_data),
        .imm_i        (imm),
        .fwd_we_i     (fwd_we),
        .fwd_addr_i   (fwd_addr),
        .fwd_data_i   (fwd_data),
        .fwd_late_i   (fwd_late),
        .issue_i      (issue),
        .issue_wd_i   (issue_wd),
        .issue_long_i (issue_long),
        .wb_valid_i   (wb_valid),
        .wb_addr_i    (wb_addr),
        .flush_i      (flush),
        .operand_o    (operand),
        .stallreq_o   (stallreq),
        .busy_o       (busy),
        .pend_cnt_o   (pend_cnt),
        .wdog_o       (wdog)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en      = '0;
        rd_addr    = '0;
        rf_data    = {32'h2222_2222, 32'h1111_1111};
        imm        = 32'h0000_1234;
        fwd_we     = '0;
        fwd_addr   = '0;
        fwd_data   = '0;
        fwd_late   = '0;
        issue      = 1'b0;
        issue_wd   = '0;
        issue_long = 1'b0;
        wb_valid   = 1'b0;
        wb_addr    = '0;
        flush      = 1'b0;
    endtask

    task automatic issue_long_op(input logic [ADDR_W-1:0] wd);
        issue      = 1'b1;
        issue_wd   = wd;
        issue_long = 1'b1;
    endtask

    initial begin
        idle();
        rst   = 1'b1;
        rd_en = 2'b11;
        #1;
        check("rst_operand", 64'(operand), 64'h0);
        check("rst_stall", 64'(stallreq), 64'h0);
        step();
        step();
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_pend", 64'(pend_cnt), 64'h0);
        check("rst_wdog", 64'(wdog), 64'h0);
        rst = 1'b0;
        idle();

        // forwarding priority: both sources write r5
        rd_en    = 2'b01;
        rd_addr  = {5'd0, 5'd5};
        fwd_we   = 2'b11;
        fwd_addr = {5'd5, 5'd5};
        fwd_data = {32'h0000_BBBB, 32'h0000_AAAA};
        #1;
        check("fwd_prio", 64'(operand[31:0]), 64'hAAAA);
        check("fwd_imm", 64'(operand[63:32]), 64'h1234);
        check("fwd_nostall", 64'(stallreq), 64'h0);
        fwd_we = 2'b10;
        #1;
        check("fwd_older", 64'(operand[31:0]), 64'hBBBB);
        rd_addr = {5'd0, 5'd6};
        #1;
        check("fwd_rf", 64'(operand[31:0]), 64'h1111_1111);
        idle();

        // load-use on port 1
        rd_en    = 2'b10;
        rd_addr  = {5'd3, 5'd0};
        fwd_we   = 2'b01;
        fwd_addr = {5'd0, 5'd3};
        fwd_data = {32'h0, 32'h0000_C3C3};
        fwd_late = 2'b01;
        #1;
        check("lu_stall", 64'(stallreq), 64'h1);
        step();
        fwd_late = 2'b00;
        #1;
        check("lu_op", 64'(operand[63:32]), 64'hC3C3);
        check("lu_clear", 64'(stallreq), 64'h0);
        fwd_we   = 2'b11;
        fwd_addr = {5'd3, 5'd3};
        fwd_late = 2'b10;
        #1;
        check("lu_oldlate", 64'(stallreq), 64'h0);
        step();
        idle();

        // long op to r30
        issue_long_op(5'd30);
        step();
        idle();
        check("long_busy", 64'(busy), 64'h4000_0000);
        check("long_pend", 64'(pend_cnt), 64'd1);
        rd_en   = 2'b01;
        rd_addr = {5'd0, 5'd30};
        #1;
        check("long_stall", 64'(stallreq), 64'h1);
        step();
        wb_valid = 1'b1;
        wb_addr  = 5'd30;
        #1;
        check("long_stall_wb", 64'(stallreq), 64'h1);
        step();
        wb_valid = 1'b0;
        #1;
        check("long_busy_clr", 64'(busy), 64'h0);
        check("long_pend_clr", 64'(pend_cnt), 64'd0);
        check("long_unstall", 64'(stallreq), 64'h0);
        step();
        idle();

        // set/clear overlap and WAW
        issue_long_op(5'd9);
        step();
        issue_long_op(5'd7);
        wb_valid = 1'b1;
        wb_addr  = 5'd7;
        step();
        idle();
        check("sc_busy", 64'(busy), 64'h0000_0280);
        check("sc_pend", 64'(pend_cnt), 64'd2);
        issue_long_op(5'd7);
        #1;
        check("waw_stall", 64'(stallreq), 64'h1);
        step();
        idle();
        check("waw_pend", 64'(pend_cnt), 64'd2);
        wb_valid = 1'b1;
        wb_addr  = 5'd7;
        step();
        check("clr7_busy", 64'(busy), 64'h0000_0200);
        wb_addr = 5'd12;
        step();
        check("clr_noop", 64'(pend_cnt), 64'd1);
        wb_addr = 5'd9;
        step();
        idle();
        check("clr9_pend", 64'(pend_cnt), 64'd0);

        // flush masks the stall and blocks the set
        issue_long_op(5'd4);
        step();
        rd_en   = 2'b01;
        rd_addr = {5'd0, 5'd4};
        issue_long_op(5'd6);
        flush = 1'b1;
        #1;
        check("fl_nostall", 64'(stallreq), 64'h0);
        step();
        idle();
        check("fl_busy", 64'(busy), 64'h0000_0010);
        check("fl_pend", 64'(pend_cnt), 64'd1);

        // watchdog on a held busy read of r4
        rd_en   = 2'b01;
        rd_addr = {5'd0, 5'd4};
        step();
        step();
        step();
        check("wd_pre", 64'(wdog), 64'h0);
        step();
        check("wd_set", 64'(wdog), 64'h1);
        step();
        check("wd_sat", 64'(wdog), 64'h1);
        idle();
        #1;
        check("wd_unstall", 64'(stallreq), 64'h0);
        step();
        check("wd_sticky", 64'(wdog), 64'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("wd_rst", 64'(wdog), 64'h0);
        check("rst2_busy", 64'(busy), 64'h0);
        wb_valid = 1'b1;
        wb_addr  = 5'd4;
        step();
        idle();
        check("rst2_pend", 64'(pend_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
